// File: rtl/aes_mixcolumns_serial_if.sv
// Handshake bundle for the column-serial MixColumns stage: upstream state in,
// downstream result out, plus a busy status flag.
interface aes_mixcolumns_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         in_inverse;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport slave (
    input  in_valid, in_state, in_bypass, in_inverse, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, in_bypass, in_inverse, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/aes_mixcolumns_serial.sv
// Column-serial AES MixColumns / InvMixColumns stage, COLS_PER_CYCLE columns per
// clock, with a single-cycle bypass for the final round.
module aes_mixcolumns_serial #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INVERSE_EN     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  aes_mixcolumns_serial_if.slave       bus
);

  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t       r_state;
  logic [1:0]   r_col_cnt;
  logic [127:0] r_src;
  logic         r_inverse;
  logic [127:0] r_out_state;
  logic         r_out_valid;
  logic         r_busy;

  logic         w_inv;
  logic [31:0]  w_col_res [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // All multiples come from the x2/x4/x8 chain: 3=x2^a, 9=x8^a, b=x8^x2^a,
  // d=x8^x4^a, e=x8^x4^x2. Row i uses bytes i, i+1, i+2, i+3 (mod 4).
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (inv) begin
        res[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                         ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                         ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                         ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      end else begin
        res[31-8*i -: 8] = x2[i]
                         ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                         ^ a[(i+2)%4]
                         ^ a[(i+3)%4];
      end
    end
    return res;
  endfunction

  // A constant-false select lets synthesis prune the inverse datapath entirely.
  assign w_inv = INVERSE_EN && r_inverse;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign w_col_res[g] = mix_col(r_src[127 - 32*(int'(r_col_cnt) + g) -: 32], w_inv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_state <= '0;
      r_busy      <= 1'b0;
      // NOTE: r_src/r_inverse are pure datapath captured on accept; they need no reset.
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_src     <= bus.in_state;
            r_inverse <= bus.in_inverse;
            r_col_cnt <= '0;
            r_busy    <= 1'b1;
            if (bus.in_bypass) begin
              r_out_state <= bus.in_state;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            r_out_state[127 - 32*(int'(r_col_cnt) + g) -: 32] <= w_col_res[g];
          end
          r_col_cnt <= r_col_cnt + COL_STEP;
          if (r_col_cnt == LAST_COL) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_state = r_out_state;
  assign bus.busy      = r_busy;

endmodule
